alu_cmd_queue: RTL and testbench
================================

# alu_cmd_queue

Upstream issue stage for the 4-bit combinational ALU. It buffers incoming ALU commands `{sel, a, b}` in a small FIFO and drives the head command onto the ALU operand and select inputs. It captures the ALU's 8-bit result into an output register, which it presents on a valid/ready result port. It also flags divide-by-zero, which the ALU itself does not detect.

## Interface
- `DEPTH`, default 4: command FIFO depth; power of two, at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: a command is offered.
- `in_ready`  out  1: the FIFO can accept a command; equals `!full`.
- `in_a`  in  4: operand A.
- `in_b`  in  4: operand B.
- `in_sel`  in  4: ALU opcode, passed through unmodified.
- `alu_a`  out  4: operand A to the ALU; the head entry's A, or 0 when the FIFO is empty.
- `alu_b`  out  4: operand B to the ALU; the head entry's B, or 0 when empty.
- `alu_sel`  out  4: opcode to the ALU; the head entry's opcode, or 0 when empty.
- `alu_out`  in  8: combinational result returned by the ALU.
- `res_valid`  out  1: the result register holds a result.
- `res_ready`  in  1: the consumer accepts the result.
- `res_data`  out  8: captured result.
- `res_sel`  out  4: opcode that produced `res_data`.
- `res_dz`  out  1: the result came from a divide (`4'b0011`) with b == 0.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy, range 0..DEPTH.

## Operation
- Push: `in_valid && in_ready` writes `{in_sel, in_a, in_b}` at the write pointer and increments the write pointer modulo DEPTH.
- Result slot is free: `!res_valid || res_ready`.
- Issue/pop happens when the FIFO is non-empty and the result slot is free. In that cycle the block:
  - captures `alu_out` into `res_data`;
  - copies the head opcode into `res_sel`;
  - sets `res_valid`;
  - increments the read pointer modulo DEPTH.
- Divide-by-zero: if the head opcode is `4'b0011` and its B is 0, the block sets `res_dz` = 1 and forces `res_data` = `8'hFF`, ignoring `alu_out`. For every other command, `res_dz` = 0.
- Drain without refill: `res_valid && res_ready` with an empty FIFO clears `res_valid`. `res_data`, `res_sel` and `res_dz` hold their last values.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full: `in_ready` = 0. There is no same-cycle bypass into a full FIFO, even if a pop happens that cycle.
- Empty: `alu_a`, `alu_b` and `alu_sel` all drive 0 (an add of 0+0).
- Results leave in strict command order. No command is dropped or duplicated.
- Width rule: the ALU evaluates in an 8-bit context, so subtraction wraps in 8 bits (3 - 5 = `8'hFE`). This block does no arithmetic on `alu_out`; it only captures it.

## Timing
- Reset values:
  - `in_ready` = 1, `count` = 0;
  - `res_valid` = 0, `res_data` = 0, `res_sel` = 0, `res_dz` = 0;
  - `alu_a` = `alu_b` = `alu_sel` = 0;
  - both pointers 0.
- FIFO storage is not reset.
- Latency: a command accepted at edge N into an empty FIFO with a free result slot gives `res_valid` = 1 with its result after edge N+1.
- Throughput: one command per cycle when `res_ready` is held high.
- `alu_*` outputs are combinational from registered state (head entry plus the empty flag). `alu_out` is sampled at the pop edge.
- `res_*` outputs are registered and stay stable while `res_valid && !res_ready`.
- Reset mid-operation: all queued commands and any pending result are discarded immediately (asynchronously). The block operates normally from the first edge after `rst` deasserts.

## Test plan
- Single add: push a=7, b=9, sel=`0000` with `res_ready` = 1 → `res_valid` one cycle later, `res_data` = `8'h10`, `res_sel` = `0000`, `res_dz` = 0.
- Back-pressure: hold `res_ready` = 0 and push 5 commands → the first issues into the result slot, `count` reaches 4, `in_ready` = 0. Then release `res_ready` → 5 results come out in push order, one per cycle, and `count` returns to 0.
- Divide-by-zero: push a=9, b=0, sel=`0011` → `res_data` = `8'hFF`, `res_dz` = 1. Next, push a=9, b=2, sel=`0011` → `res_data` = 4, `res_dz` = 0.
- Subtract wrap and multiply: push a=3, b=5, sel=`0001` → `res_data` = `8'hFE`. Push a=15, b=15, sel=`0010` → `res_data` = `8'hE1`.
- Streaming: push a new command every cycle for 12 cycles with `res_ready` = 1, including one full wrap of the pointers → 12 correct results in order, `count` never above 1, and exactly one result accepted per cycle.
- Reset mid-stream: with 3 commands queued and `res_valid` = 1, pulse `rst` between clock edges → immediately `res_valid` = 0, `count` = 0, `in_ready` = 1 and `alu_sel` = 0. The next push after reset produces its own result only.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO in front of the 4-bit combinational ALU.
// Holds {sel, a, b} commands, drives the head entry onto the ALU inputs and
// captures the ALU result (or a forced divide-by-zero marker) into a
// valid/ready result register.
module alu_cmd_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [3:0]               in_sel,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [3:0]               alu_sel,
    input  logic [7:0]               alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic [3:0]               res_sel,
    output logic                     res_dz,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    OP_DIV   = 4'b0011;

    // Entry layout: [11:8] sel, [7:4] a, [3:0] b
    logic [11:0]   mem_q [DEPTH];
    logic [11:0]   entry_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q,  res_data_d;
    logic [3:0]    res_sel_q,   res_sel_d;
    logic          res_dz_q,    res_dz_d;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          slot_free;
    logic          head_dz;
    logic [11:0]   head;

    // Handshake decode and ALU operand drive from the head entry
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        push      = in_valid && !full;
        slot_free = !res_valid_q || res_ready;
        pop       = !empty && slot_free;
        head      = mem_q[rd_ptr_q];
        entry_d   = {in_sel, in_a, in_b};

        alu_sel   = '0;
        alu_a     = '0;
        alu_b     = '0;
        if (!empty) begin
            alu_sel = head[11:8];
            alu_a   = head[7:4];
            alu_b   = head[3:0];
        end
        head_dz   = !empty && (head[11:8] == OP_DIV) && (head[3:0] == 4'd0);
    end

    // Next-state for pointers, occupancy and the result register
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;
        res_dz_d    = res_dz_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            res_valid_d = 1'b1;
            res_sel_d   = head[11:8];
            res_dz_d    = head_dz;
            res_data_d  = head_dz ? 8'hFF : alu_out;
        end else if (res_valid_q && res_ready) begin
            // Consumer took the result and nothing is queued: data/sel/dz hold
            res_valid_d = 1'b0;
        end
    end

    // Control and result state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
            res_dz_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
            res_dz_q    <= res_dz_d;
        end
    end

    // Command storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign in_ready  = !full;
    assign count     = count_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sel   = res_sel_q;
    assign res_dz    = res_dz_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [3:0] in_sel = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [3:0] res_sel;
    logic       res_dz;
    logic [2:0] count;

    int n_total = 0;
    int n_pass  = 0;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sel   (res_sel),
        .res_dz    (res_dz),
        .count     (count)
    );

    always #5 clk = ~clk;

    // The external ALU: 8-bit context; divide by zero returns 0 (undetected)
    function automatic logic [7:0] ref_alu(input logic [3:0] sel,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        logic [7:0] a8;
        logic [7:0] b8;
        a8 = {4'd0, a};
        b8 = {4'd0, b};
        case (sel)
            4'b0000: return a8 + b8;
            4'b0001: return a8 - b8;
            4'b0010: return a8 * b8;
            4'b0011: return (b == 4'd0) ? 8'h00 : a8 / b8;
            default: return a8 & b8;
        endcase
    endfunction

    assign alu_out = ref_alu(alu_sel, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain queue of commands plus one result slot
    logic [11:0] mq[$];
    logic        m_rv   = 1'b0;
    logic [7:0]  m_data = '0;
    logic [3:0]  m_sel  = '0;
    logic        m_dz   = 1'b0;

    always @(posedge rst) begin
        mq.delete();
        m_rv   = 1'b0;
        m_data = '0;
        m_sel  = '0;
        m_dz   = 1'b0;
    end

    // At each falling edge: compare DUT to model, then advance the model with
    // the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        logic [11:0] e;
        logic        do_push;
        logic        do_pop;
        if (!rst) begin
            check("in_ready", in_ready, mq.size() != DEPTH);
            check("count", count, mq.size());
            check("alu_sel", alu_sel, mq.size() > 0 ? mq[0][11:8] : 4'd0);
            check("alu_a", alu_a, mq.size() > 0 ? mq[0][7:4] : 4'd0);
            check("alu_b", alu_b, mq.size() > 0 ? mq[0][3:0] : 4'd0);
            check("res_valid", res_valid, m_rv);
            check("res_data", res_data, m_data);
            check("res_sel", res_sel, m_sel);
            check("res_dz", res_dz, m_dz);

            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && (!m_rv || res_ready);
            if (do_pop) begin
                e     = mq.pop_front();
                m_rv  = 1'b1;
                m_sel = e[11:8];
                if (e[11:8] == 4'b0011 && e[3:0] == 4'd0) begin
                    m_data = 8'hFF;
                    m_dz   = 1'b1;
                end else begin
                    m_data = ref_alu(e[11:8], e[7:4], e[3:0]);
                    m_dz   = 1'b0;
                end
            end else if (m_rv && res_ready) begin
                m_rv = 1'b0;
            end
            if (do_push) mq.push_back({in_sel, in_a, in_b});
        end
    end

    task automatic drive(input logic [3:0] sel, input logic [3:0] a,
                         input logic [3:0] b);
        in_valid = 1'b1;
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_sel", res_sel, 0);
        check("rst_res_dz", res_dz, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_alu_ab", {alu_a, alu_b}, 0);
        rst = 1'b0;

        // Single add, one-cycle latency
        res_ready = 1'b1;
        drive(4'b0000, 4'd7, 4'd9);
        tick();
        in_valid = 1'b0;
        check("add_count1", count, 1);
        check("add_alu_a", alu_a, 7);
        check("add_alu_b", alu_b, 9);
        check("add_not_yet", res_valid, 0);
        tick();
        check("add_valid", res_valid, 1);
        check("add_data", res_data, 8'h10);
        check("add_sel", res_sel, 0);
        check("add_dz", res_dz, 0);
        tick();
        check("add_drained", res_valid, 0);
        check("add_hold_data", res_data, 8'h10);

        // Back-pressure: 5 pushes with consumer stalled
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(4'b0000, 4'(i), 4'(i));
            tick();
        end
        in_valid = 1'b0;
        check("bp_count_full", count, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", res_valid, 1);
        check("bp_stall_data", res_data, 2);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_order_valid", res_valid, 1);
            check("bp_order_data", res_data, 32'((i + 1) * 2));
            tick();
        end
        check("bp_done_valid", res_valid, 0);
        check("bp_done_count", count, 0);

        // Divide-by-zero then a normal divide
        drive(4'b0011, 4'd9, 4'd0);
        tick();
        drive(4'b0011, 4'd9, 4'd2);
        tick();
        in_valid = 1'b0;
        check("dz_data", res_data, 8'hFF);
        check("dz_flag", res_dz, 1);
        check("dz_sel", res_sel, 4'b0011);
        tick();
        check("div_data", res_data, 4);
        check("div_flag", res_dz, 0);
        tick();

        // Subtract wrap and multiply
        drive(4'b0001, 4'd3, 4'd5);
        tick();
        drive(4'b0010, 4'd15, 4'd15);
        tick();
        in_valid = 1'b0;
        check("sub_data", res_data, 8'hFE);
        check("sub_sel", res_sel, 4'b0001);
        tick();
        check("mul_data", res_data, 8'hE1);
        tick();

        // Streaming 12 commands back to back, wrapping the pointers
        for (int i = 0; i < 12; i++) begin
            drive(4'(i % 4), 4'(i + 2), 4'(i % 5 + 1));
            tick();
            check("stream_count_le1", count <= 1, 1);
            if (i > 0) check("stream_one_per_cycle", res_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_last_valid", res_valid, 1);
        check("stream_empty", count, 0);
        tick();

        // Reset mid-stream: 3 queued plus a pending result
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0010, 4'(i + 1), 4'd3);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", count, 3);
        check("pre_rst_valid", res_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_alu_sel", alu_sel, 0);
        #1 rst = 1'b0;
        tick();
        res_ready = 1'b1;
        drive(4'b0000, 4'd6, 4'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", res_valid, 1);
        check("post_rst_data", res_data, 7);
        tick();
        check("post_rst_drained", res_valid, 0);
        repeat (2) tick();
        check("post_rst_no_extra", res_valid, 0);
        check("post_rst_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
